// File: rtl/hist_eq_pkg.sv
// Shared encodings and sizes for the histogram-equalisation pipeline controller.
package hist_eq_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LAUNCH = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] FINISH = 3'd3;
  localparam logic [2:0] ERR    = 3'd4;

  localparam int STG_HIST = 0;
  localparam int STG_CDF  = 1;
  localparam int STG_DIV  = 2;

  localparam int SC_AW = 16;
  localparam int SC_DW = 128;

  // Width of the stage index; matches the 2-bit err_stage report.
  localparam int IDX_W = 2;
  typedef logic [IDX_W-1:0] stage_idx_t;

endpackage

// File: rtl/scratch_port_mux.sv
// Routes the owning stage's flattened scratch-memory request fields onto the
// single memory port; everything reads as zero when no grant is valid.
module scratch_port_mux #(
  parameter int NUM_STAGES = 3,
  parameter int AW         = 16,
  parameter int DW         = 128,
  parameter int IW         = 2
) (
  input  logic                     i_grant_vld,
  input  logic [IW-1:0]            i_idx,
  input  logic [NUM_STAGES*AW-1:0] i_rd_addr1,
  input  logic [NUM_STAGES*AW-1:0] i_rd_addr2,
  input  logic [NUM_STAGES*AW-1:0] i_wt_addr,
  input  logic [NUM_STAGES*DW-1:0] i_wt_data,
  input  logic [NUM_STAGES-1:0]    i_wt_en,
  output logic [AW-1:0]            o_rd_addr1,
  output logic [AW-1:0]            o_rd_addr2,
  output logic [AW-1:0]            o_wt_addr,
  output logic [DW-1:0]            o_wt_data,
  output logic                     o_wt_en
);

  always_comb begin
    o_rd_addr1 = '0;
    o_rd_addr2 = '0;
    o_wt_addr  = '0;
    o_wt_data  = '0;
    o_wt_en    = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (i_grant_vld && (i_idx == IW'(i))) begin
        o_rd_addr1 = i_rd_addr1[i*AW +: AW];
        o_rd_addr2 = i_rd_addr2[i*AW +: AW];
        o_wt_addr  = i_wt_addr[i*AW +: AW];
        o_wt_data  = i_wt_data[i*DW +: DW];
        o_wt_en    = i_wt_en[i];
      end
    end
  end

endmodule

// File: rtl/hist_eq_sequencer.sv
// Phase controller: launches each pipeline stage in turn with a held enable,
// waits for its done pulse under a watchdog, and grants it the scratch memory.
module hist_eq_sequencer
  import hist_eq_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int CDF_STAGE  = STG_CDF,
  parameter int EN_CYCLES  = 10,
  parameter int TIMEOUT    = 65535,
  parameter int AW         = SC_AW,
  parameter int DW         = SC_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [1:0]               err_stage,
  output logic [NUM_STAGES-1:0]    stg_enable,
  input  logic [NUM_STAGES-1:0]    stg_done,
  input  logic [31:0]              cdf_min_in,
  output logic [31:0]              cdf_min,
  input  logic [NUM_STAGES*AW-1:0] stg_rd_addr1,
  input  logic [NUM_STAGES*AW-1:0] stg_rd_addr2,
  input  logic [NUM_STAGES*AW-1:0] stg_wt_addr,
  input  logic [NUM_STAGES*DW-1:0] stg_wt_data,
  input  logic [NUM_STAGES-1:0]    stg_wt_en,
  output logic [AW-1:0]            mem_rd_addr1,
  output logic [AW-1:0]            mem_rd_addr2,
  output logic [AW-1:0]            mem_wt_addr,
  output logic [DW-1:0]            mem_wt_data,
  output logic                     mem_wt_en
);

  localparam stage_idx_t  LAST_IDX = stage_idx_t'(NUM_STAGES - 1);
  localparam stage_idx_t  CDF_IDX  = stage_idx_t'(CDF_STAGE);
  localparam logic [7:0]  EN_LAST  = 8'(EN_CYCLES - 1);
  localparam logic [19:0] WD_LAST  = 20'(TIMEOUT - 1);

  logic [2:0]            r_state;
  stage_idx_t            r_idx;
  logic [7:0]            r_en_cnt;
  logic [19:0]           r_wd_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [1:0]            r_err_stage;
  logic [NUM_STAGES-1:0] r_stg_enable;
  logic [31:0]           r_cdf_min;

  logic                  w_active;
  logic                  w_done_sel;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_restart;
  stage_idx_t            w_next_idx;

  function automatic logic [NUM_STAGES-1:0] f_onehot(input stage_idx_t idx);
    f_onehot = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (idx == stage_idx_t'(i)) f_onehot[i] = 1'b1;
    end
  endfunction

  assign w_active   = (r_state == LAUNCH) || (r_state == WAIT);
  assign w_last     = (r_idx == LAST_IDX);
  assign w_next_idx = r_idx + 1'b1;
  assign w_restart  = start && ((r_state == IDLE) || (r_state == ERR));

  // Only the done bit of the stage currently owning the sequence counts.
  always_comb begin
    w_done_sel = 1'b0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (r_idx == stage_idx_t'(i)) w_done_sel = stg_done[i];
    end
  end

  assign w_accept = w_active && w_done_sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_en_cnt     <= '0;
      r_wd_cnt     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
      r_err_stage  <= '0;
      r_stg_enable <= '0;
      r_cdf_min    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, ERR: begin
          if (w_restart) begin
            r_state      <= LAUNCH;
            r_idx        <= '0;
            r_en_cnt     <= '0;
            r_error      <= 1'b0;
            r_err_stage  <= '0;
            r_busy       <= 1'b1;
            r_stg_enable <= f_onehot('0);
          end
        end
        LAUNCH, WAIT: begin
          r_en_cnt <= r_en_cnt + 1'b1;
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // An accepted done takes priority over both the enable count and the watchdog.
          if (w_done_sel) begin
            if (w_last) begin
              r_state      <= FINISH;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_stg_enable <= '0;
            end else begin
              r_state      <= LAUNCH;
              r_idx        <= w_next_idx;
              r_en_cnt     <= '0;
              r_stg_enable <= f_onehot(w_next_idx);
            end
          end else if ((r_state == LAUNCH) && (r_en_cnt == EN_LAST)) begin
            r_state      <= WAIT;
            r_wd_cnt     <= '0;
            r_stg_enable <= '0;
          end else if ((r_state == WAIT) && (r_wd_cnt == WD_LAST)) begin
            r_state     <= ERR;
            r_error     <= 1'b1;
            r_err_stage <= r_idx;
            r_busy      <= 1'b0;
          end
        end
        FINISH: begin
          r_state <= IDLE;
        end
        default: begin
          r_state      <= IDLE;
          r_busy       <= 1'b0;
          r_stg_enable <= '0;
        end
      endcase

      if (w_accept && (r_idx == CDF_IDX)) r_cdf_min <= cdf_min_in;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign error      = r_error;
  assign err_stage  = r_err_stage;
  assign stg_enable = r_stg_enable;
  assign cdf_min    = r_cdf_min;

  scratch_port_mux #(
    .NUM_STAGES (NUM_STAGES),
    .AW         (AW),
    .DW         (DW),
    .IW         (IDX_W)
  ) u_mux (
    .i_grant_vld (w_active),
    .i_idx       (r_idx),
    .i_rd_addr1  (stg_rd_addr1),
    .i_rd_addr2  (stg_rd_addr2),
    .i_wt_addr   (stg_wt_addr),
    .i_wt_data   (stg_wt_data),
    .i_wt_en     (stg_wt_en),
    .o_rd_addr1  (mem_rd_addr1),
    .o_rd_addr2  (mem_rd_addr2),
    .o_wt_addr   (mem_wt_addr),
    .o_wt_data   (mem_wt_data),
    .o_wt_en     (mem_wt_en)
  );

endmodule

// File: tb/tb_hist_eq_sequencer.sv
// Directed bench for hist_eq_sequencer: sequencing, memory ownership, watchdog,
// early/stray done handling, restart and mid-run reset.
module tb_hist_eq_sequencer;

  localparam int NS  = 3;
  localparam int AW  = 16;
  localparam int DW  = 128;
  localparam int ENC = 10;
  localparam int TO  = 100;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             busy;
  logic             done;
  logic             error;
  logic [1:0]       err_stage;
  logic [NS-1:0]    stg_enable;
  logic [NS-1:0]    stg_done;
  logic [31:0]      cdf_min_in;
  logic [31:0]      cdf_min;
  logic [NS*AW-1:0] stg_rd_addr1;
  logic [NS*AW-1:0] stg_rd_addr2;
  logic [NS*AW-1:0] stg_wt_addr;
  logic [NS*DW-1:0] stg_wt_data;
  logic [NS-1:0]    stg_wt_en;
  logic [AW-1:0]    mem_rd_addr1;
  logic [AW-1:0]    mem_rd_addr2;
  logic [AW-1:0]    mem_wt_addr;
  logic [DW-1:0]    mem_wt_data;
  logic             mem_wt_en;

  always #5 clk = ~clk;

  hist_eq_sequencer #(
    .NUM_STAGES (NS),
    .CDF_STAGE  (1),
    .EN_CYCLES  (ENC),
    .TIMEOUT    (TO),
    .AW         (AW),
    .DW         (DW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .err_stage    (err_stage),
    .stg_enable   (stg_enable),
    .stg_done     (stg_done),
    .cdf_min_in   (cdf_min_in),
    .cdf_min      (cdf_min),
    .stg_rd_addr1 (stg_rd_addr1),
    .stg_rd_addr2 (stg_rd_addr2),
    .stg_wt_addr  (stg_wt_addr),
    .stg_wt_data  (stg_wt_data),
    .stg_wt_en    (stg_wt_en),
    .mem_rd_addr1 (mem_rd_addr1),
    .mem_rd_addr2 (mem_rd_addr2),
    .mem_wt_addr  (mem_wt_addr),
    .mem_wt_data  (mem_wt_data),
    .mem_wt_en    (mem_wt_en)
  );

  typedef struct packed {
    logic [1:0]  own;     // stage expected to own the memory (3 = none)
    logic [2:0]  wt_en;
    logic [15:0] a0;
    logic [15:0] a1;
    logic [15:0] a2;
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_rd1;
    logic [15:0] exp_rd2;
    logic [15:0] exp_d;
  } vec_t;

  vec_t vecs [8];

  int total = 0;
  int bad   = 0;

  int   cnt    [NS];
  int   first  [NS];
  int   target [NS];
  int   dly    [NS];
  logic prev   [NS];
  int   oh_err, ndone, done_k, err_k, cur;
  logic busy_at_done, busy_after, en2_seen;
  logic [31:0] cdf71, cdf72;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_bus(input logic [2:0] we, input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2);
    stg_wt_en    = we;
    stg_wt_addr  = {a2, a1, a0};
    stg_rd_addr1 = {a2 ^ 16'h0F00, a1 ^ 16'h0F00, a0 ^ 16'h0F00};
    stg_rd_addr2 = {a2 ^ 16'hF000, a1 ^ 16'hF000, a0 ^ 16'hF000};
    stg_wt_data  = {{8{a2}}, {8{a1}}, {8{a0}}};
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{2'd0, 3'b100, 16'h0010, 16'h0020, 16'h0040, 1'b0, 16'h0010, 16'h0F10, 16'hF010, 16'h0010};
    vecs[1] = '{2'd0, 3'b001, 16'h0010, 16'h0020, 16'h0040, 1'b1, 16'h0010, 16'h0F10, 16'hF010, 16'h0010};
    vecs[2] = '{2'd0, 3'b110, 16'h0001, 16'h0002, 16'h0040, 1'b0, 16'h0001, 16'h0F01, 16'hF001, 16'h0001};
    vecs[3] = '{2'd1, 3'b010, 16'h0010, 16'h0020, 16'h0040, 1'b1, 16'h0020, 16'h0F20, 16'hF020, 16'h0020};
    vecs[4] = '{2'd1, 3'b101, 16'h0010, 16'h0020, 16'h0040, 1'b0, 16'h0020, 16'h0F20, 16'hF020, 16'h0020};
    vecs[5] = '{2'd2, 3'b100, 16'h0010, 16'h0020, 16'h0040, 1'b1, 16'h0040, 16'h0F40, 16'hF040, 16'h0040};
    vecs[6] = '{2'd2, 3'b011, 16'h0010, 16'h0020, 16'h0040, 1'b0, 16'h0040, 16'h0F40, 16'hF040, 16'h0040};
    vecs[7] = '{2'd3, 3'b111, 16'h0010, 16'h0020, 16'h0040, 1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

    reset = 1'b1; start = 1'b0; stg_done = '0; cdf_min_in = '0;
    set_bus(3'b111, 16'h0001, 16'h0002, 16'h0003);
    repeat (3) tick;

    // Reset state
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_error", 128'(error), 128'(0));
    chk("rst_err_stage", 128'(err_stage), 128'(0));
    chk("rst_enable", 128'(stg_enable), 128'(0));
    chk("rst_cdf_min", 128'(cdf_min), 128'(0));
    chk("rst_mem_we", 128'(mem_wt_en), 128'(0));
    chk("rst_mem_addr", 128'(mem_wt_addr), 128'(0));
    chk("rst_mem_rd1", 128'(mem_rd_addr1), 128'(0));
    chk("rst_mem_data", mem_wt_data, 128'(0));
    set_bus(3'b000, 16'h0, 16'h0, 16'h0);
    reset = 1'b0;
    repeat (5) tick;

    // Nominal run with stub stages finishing 20/30/40 cycles after enable falls
    dly[0] = 20; dly[1] = 30; dly[2] = 40;
    for (int i = 0; i < NS; i++) begin
      cnt[i] = 0; first[i] = -1; target[i] = -1; prev[i] = 1'b0;
    end
    oh_err = 0; ndone = 0; done_k = -1; busy_at_done = 1'b1; busy_after = 1'b1;
    cdf71 = '1; cdf72 = '0;
    cdf_min_in = 32'd18;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k <= 200; k++) begin
      stg_done = '0;
      for (int i = 0; i < NS; i++) begin
        if (stg_enable[i]) begin
          cnt[i]++;
          if (first[i] < 0) first[i] = k;
        end
        if (!stg_enable[i] && prev[i]) target[i] = k + dly[i];
        prev[i] = stg_enable[i];
      end
      if ($countones(stg_enable) > 1) oh_err++;
      if (done_k >= 0 && k == done_k + 1) busy_after = busy;
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          busy_at_done = busy;
        end
      end
      if (k == 71) cdf71 = cdf_min;
      if (k == 72) cdf72 = cdf_min;
      for (int i = 0; i < NS; i++) if (k == target[i]) stg_done[i] = 1'b1;
      tick;
    end
    stg_done = '0;
    chk("nom_first0", 128'(first[0]), 128'(0));
    chk("nom_first1", 128'(first[1]), 128'(31));
    chk("nom_first2", 128'(first[2]), 128'(72));
    chk("nom_len0", 128'(cnt[0]), 128'(ENC));
    chk("nom_len1", 128'(cnt[1]), 128'(ENC));
    chk("nom_len2", 128'(cnt[2]), 128'(ENC));
    chk("nom_onehot", 128'(oh_err), 128'(0));
    chk("nom_cdf_before", 128'(cdf71), 128'(0));
    chk("nom_cdf_after", 128'(cdf72), 128'(18));
    chk("nom_done_cycle", 128'(done_k), 128'(123));
    chk("nom_done_count", 128'(ndone), 128'(1));
    chk("nom_busy_at_done", 128'(busy_at_done), 128'(0));
    chk("nom_busy_after", 128'(busy_after), 128'(0));
    chk("nom_error", 128'(error), 128'(0));

    // Memory ownership table: advance phases by pulsing the owner's done
    start = 1'b1; tick; start = 1'b0;
    cur = 0;
    for (int r = 0; r < 8; r++) begin
      while (cur < int'(vecs[r].own)) begin
        stg_done = 3'(1 << cur);
        tick;
        stg_done = '0;
        cur++;
      end
      set_bus(vecs[r].wt_en, vecs[r].a0, vecs[r].a1, vecs[r].a2);
      #1;
      chk($sformatf("mux%0d_we", r), 128'(mem_wt_en), 128'(vecs[r].exp_we));
      chk($sformatf("mux%0d_waddr", r), 128'(mem_wt_addr), 128'(vecs[r].exp_addr));
      chk($sformatf("mux%0d_rd1", r), 128'(mem_rd_addr1), 128'(vecs[r].exp_rd1));
      chk($sformatf("mux%0d_rd2", r), 128'(mem_rd_addr2), 128'(vecs[r].exp_rd2));
      chk($sformatf("mux%0d_data", r), mem_wt_data, {8{vecs[r].exp_d}});
    end
    set_bus(3'b000, 16'h0, 16'h0, 16'h0);
    tick;

    // Watchdog: stage 1 never completes
    err_k = -1; en2_seen = 1'b0;
    start = 1'b1; tick; start = 1'b0;
    for (int k = 0; k <= 160; k++) begin
      stg_done = '0;
      if (stg_enable[2]) en2_seen = 1'b1;
      if (error && err_k < 0) err_k = k;
      if (k == 12) stg_done = 3'b001;
      tick;
    end
    stg_done = '0;
    chk("wd_error_cycle", 128'(err_k), 128'(123));
    chk("wd_no_stage2", 128'(en2_seen), 128'(0));
    chk("wd_error_sticky", 128'(error), 128'(1));
    chk("wd_err_stage", 128'(err_stage), 128'(1));
    chk("wd_busy", 128'(busy), 128'(0));
    chk("wd_enable", 128'(stg_enable), 128'(0));

    // Restart from error, with a stray done and an early done in launch
    cdf_min_in = 32'd77;
    start = 1'b1; tick; start = 1'b0;
    chk("rs_error_clr", 128'(error), 128'(0));
    chk("rs_err_stage_clr", 128'(err_stage), 128'(0));
    chk("rs_busy", 128'(busy), 128'(1));
    chk("rs_enable0", 128'(stg_enable), 128'(3'b001));
    chk("rs_cdf_held", 128'(cdf_min), 128'(18));
    stg_done = 3'b100; tick; stg_done = '0;
    chk("stray_ignored", 128'(stg_enable), 128'(3'b001));
    tick;
    stg_done = 3'b001; tick; stg_done = '0;
    chk("early_done_adv", 128'(stg_enable), 128'(3'b010));
    stg_done = 3'b010; tick; stg_done = '0;
    chk("rs_enable2", 128'(stg_enable), 128'(3'b100));
    chk("rs_cdf_new", 128'(cdf_min), 128'(77));
    stg_done = 3'b100; tick; stg_done = '0;
    chk("rs_done", 128'(done), 128'(1));
    chk("rs_done_busy", 128'(busy), 128'(0));
    chk("rs_done_err", 128'(error), 128'(0));
    tick;
    chk("rs_done_pulse", 128'(done), 128'(0));

    // Reset in the middle of stage 1's wait
    cdf_min_in = 32'd5;
    start = 1'b1; tick; start = 1'b0;
    stg_done = 3'b001; tick; stg_done = '0;
    repeat (12) tick;
    chk("mr_in_wait_en", 128'(stg_enable), 128'(0));
    chk("mr_in_wait_busy", 128'(busy), 128'(1));
    set_bus(3'b111, 16'h0011, 16'h0022, 16'h0033);
    #1;
    chk("mr_owner_we", 128'(mem_wt_en), 128'(1));
    chk("mr_owner_addr", 128'(mem_wt_addr), 128'(16'h0022));
    chk("mr_cdf_pre", 128'(cdf_min), 128'(77));
    reset = 1'b1; tick;
    chk("mr_busy", 128'(busy), 128'(0));
    chk("mr_enable", 128'(stg_enable), 128'(0));
    chk("mr_mem_we", 128'(mem_wt_en), 128'(0));
    chk("mr_mem_addr", 128'(mem_wt_addr), 128'(0));
    chk("mr_cdf", 128'(cdf_min), 128'(0));
    reset = 1'b0; tick;
    start = 1'b1; tick; start = 1'b0;
    chk("mr_rerun_en", 128'(stg_enable), 128'(3'b001));
    chk("mr_rerun_busy", 128'(busy), 128'(1));
    chk("mr_rerun_addr", 128'(mem_wt_addr), 128'(16'h0011));
    chk("mr_rerun_we", 128'(mem_wt_en), 128'(1));
    reset = 1'b1; tick; reset = 1'b0;
    set_bus(3'b000, 16'h0, 16'h0, 16'h0);
    tick;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
